instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: InstructionFetch

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, 16, max cycles MemReq may wait for MemAck (used only with the timeout feature, range 2..255).
REQ-002 SHALL have ports: Clock  in  1  single clock, all state on rising edge.
REQ-003 Reset  in  1  asynchronous, active-low reset.
REQ-004 CounterValue  in  16  signed current PC from ProgramCounter.
REQ-005 MemReq  out  1  instruction-memory read request; MemAddr  out  16  read address.
REQ-006 MemAck  in  1  read completes; MemData  in  16  read data, valid when MemAck=1.
REQ-007 Stall  in  1  downstream not ready; holds the decoded instruction.
REQ-008 Instruction  out  16  instruction register; InstrValid  out  1  one-cycle pulse per issued instruction.
REQ-009 LoadEnable  out  1, LoadValue  out  16 signed, OffsetEnable  out  1, Offset  out  9 signed: PC update controls to ProgramCounter.
REQ-010 Fault  out  1  sticky fetch-timeout flag (constant 0 without the timeout feature).

Function
REQ-011 SHALL implement FSM states IDLE, FETCH, ISSUE, FETCH_TGT, HALTED.
REQ-012 IDLE -> FETCH unconditionally on the first edge after reset release.
REQ-013 FETCH: MemReq=1, MemAddr=CounterValue; hold both stable until an edge with MemAck=1; on that edge load Instruction<=MemData and go to ISSUE.
REQ-014 MemAck SHALL be ignored while MemReq=0; MemAck in the same cycle MemReq rises SHALL complete the read (zero-wait memory).
REQ-015 Opcode = Instruction[15:12]: 4'hC BRA (relative), 4'hD JMP (two-word absolute), 4'hF HALT, all others sequential.
REQ-016 ISSUE with Stall=1: hold; no pulses; Instruction unchanged.
REQ-017 ISSUE with Stall=0, sequential: pulse InstrValid and OffsetEnable with Offset=+1 for one cycle; next state FETCH.
REQ-018 ISSUE with Stall=0, BRA: pulse InstrValid and OffsetEnable with Offset=Instruction[8:0] (sign preserved; Offset 0 legal, refetches same address); next FETCH.
REQ-019 ISSUE with Stall=0, JMP: pulse InstrValid only; next FETCH_TGT.
REQ-020 FETCH_TGT: MemReq=1, MemAddr=CounterValue+1 (16-bit wrap, 16'hFFFF+1=16'h0000); on MemAck pulse LoadEnable with LoadValue=MemData for one cycle; next FETCH.
REQ-021 ISSUE with Stall=0, HALT: pulse InstrValid; next HALTED; HALTED issues no requests or pulses until reset.
REQ-022 LoadEnable and OffsetEnable SHALL never be asserted in the same cycle; each update pulse lasts exactly one cycle.
REQ-023 Minimum throughput: sequential instruction every 2 cycles with zero-wait memory (FETCH, ISSUE).

Reset
REQ-024 Reset=0 SHALL immediately force: state IDLE, MemReq=0, MemAddr=0, Instruction=0, InstrValid=0, LoadEnable=0, LoadValue=0, OffsetEnable=0, Offset=0, Fault=0.
REQ-025 Reset mid-fetch SHALL drop MemReq asynchronously; a MemAck arriving during/after reset SHALL be ignored.

Configuration
REQ-026 Macro INSTRUCTION_FETCH_TIMEOUT_EN defined: wait counter increments each FETCH/FETCH_TGT cycle with MemAck=0; reaching TIMEOUT_CYCLES sets Fault=1, drops MemReq, enters HALTED; counter clears on MemAck.
REQ-027 Macro undefined: no counter, Fault tied 0, FETCH/FETCH_TGT wait indefinitely.

Structure
REQ-028 Shared package cpu_pkg SHALL hold opcode constants (OP_BRA, OP_JMP, OP_HALT), fetch-state enum, and width constants (16-bit word, 9-bit offset).
REQ-029 Timeout counter SHALL be sub-module FetchWatchdog, instantiated only under INSTRUCTION_FETCH_TIMEOUT_EN.

Verification
REQ-030 Reset release, CounterValue=16'h0010, MemData=16'h1234, MemAck after 2 wait cycles -> MemAddr=16'h0010 held 3 cycles, then InstrValid and OffsetEnable pulse with Offset=+1.
REQ-031 MemData=16'hC1FE (BRA -2) -> OffsetEnable pulse with Offset=9'h1FE, LoadEnable=0.
REQ-032 CounterValue=16'hFFFF, JMP then target 16'h0200 -> second MemAddr=16'h0000, LoadEnable pulse with LoadValue=16'h0200.
REQ-033 Stall=1 for 5 cycles in ISSUE -> no pulses, Instruction stable; pulses one cycle after Stall=0.
REQ-034 HALT 16'hF000 -> one InstrValid, then MemReq=0 forever; Reset=0 mid-FETCH -> MemReq=0 same cycle.
REQ-035 With INSTRUCTION_FETCH_TIMEOUT_EN, MemAck held 0 -> Fault=1 after 16 wait cycles, MemReq=0, HALTED.

Source files
------------

// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg -- shared definitions for the instruction fetch slice.
//   WORD_W / OFFSET_W / OPCODE_W : instruction word, PC offset and opcode widths
//   OP_BRA / OP_JMP / OP_HALT    : opcodes decoded from Instruction[15:12]
//   fetch_state_t                : fetch FSM state encoding
//   pc_update_t                  : PC update bundle sent to ProgramCounter
// -----------------------------------------------------------------------------
package cpu_pkg;

  localparam int WORD_W   = 16;
  localparam int OFFSET_W = 9;
  localparam int OPCODE_W = 4;

  localparam logic [OPCODE_W-1:0] OP_BRA  = 4'hC;  // relative branch, offset in [8:0]
  localparam logic [OPCODE_W-1:0] OP_JMP  = 4'hD;  // absolute jump, target in next word
  localparam logic [OPCODE_W-1:0] OP_HALT = 4'hF;  // stop fetching until reset

  typedef enum logic [2:0] {
    FS_IDLE      = 3'd0,
    FS_FETCH     = 3'd1,
    FS_ISSUE     = 3'd2,
    FS_FETCH_TGT = 3'd3,
    FS_HALTED    = 3'd4
  } fetch_state_t;

  typedef struct packed {
    logic                ld_en;
    logic [WORD_W-1:0]   ld_val;
    logic                off_en;
    logic [OFFSET_W-1:0] off;
  } pc_update_t;

  function automatic logic [OPCODE_W-1:0] opcode_of(input logic [WORD_W-1:0] w);
    return w[WORD_W-1 -: OPCODE_W];
  endfunction

endpackage

// File: rtl/FetchWatchdog.sv
// -----------------------------------------------------------------------------
// FetchWatchdog -- counts cycles a memory read has been outstanding.
//   Clock, Reset   : clock, asynchronous active-low reset
//   Active         : a read is being requested this cycle (FETCH / FETCH_TGT)
//   MemAck         : read completes this cycle; clears the count
//   Expire         : combinational; high on the TIMEOUT_CYCLES-th cycle without
//                    an ack, so the owner can react on that same edge
// Only compiled into the design when INSTRUCTION_FETCH_TIMEOUT_EN is defined;
// otherwise the file is empty so no stray top-level module appears.
// -----------------------------------------------------------------------------
`ifdef INSTRUCTION_FETCH_TIMEOUT_EN
module FetchWatchdog #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic Clock,
  input  logic Reset,
  input  logic Active,
  input  logic MemAck,
  output logic Expire
);

  // TIMEOUT_CYCLES is limited to 2..255, so 8 bits always suffice.
  localparam int CNT_W = 8;

  logic [CNT_W-1:0] wait_q;

  assign Expire = Active && !MemAck && (wait_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      wait_q <= '0;
    end else if (!Active || MemAck || Expire) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_q + CNT_W'(1);
    end
  end

endmodule
`endif

// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch -- fetches one instruction word at a time, holds it in the
// instruction register until downstream accepts it, and tells ProgramCounter
// how to advance.
//
// Ports
//   Clock, Reset          : clock (rising edge), asynchronous active-low reset
//   CounterValue          : current PC from ProgramCounter
//   MemReq, MemAddr       : instruction memory read request / address
//   MemAck, MemData       : read completion / data (valid with MemAck)
//   Stall                 : downstream not ready, hold the current instruction
//   Instruction           : instruction register
//   InstrValid            : one-cycle pulse per issued instruction
//   LoadEnable, LoadValue : absolute PC load (JMP target)
//   OffsetEnable, Offset  : relative PC step (+1 or BRA offset)
//   Fault                 : sticky fetch timeout flag
//
// Optional feature: define INSTRUCTION_FETCH_TIMEOUT_EN to add a watchdog that
// halts the fetcher with Fault=1 after TIMEOUT_CYCLES cycles without MemAck.
// Without it Fault is 0 and reads wait forever.
//
// Request and PC-update outputs are decoded from the registered state, so an
// asynchronous reset drops them in the same cycle. PC updates are issued in the
// cycle the decision is made; ProgramCounter takes them on the following edge,
// which is exactly when the next FETCH starts presenting CounterValue.
// -----------------------------------------------------------------------------
module instruction_fetch
  import cpu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                       Clock,
  input  logic                       Reset,
  input  logic signed [WORD_W-1:0]   CounterValue,
  output logic                       MemReq,
  output logic        [WORD_W-1:0]   MemAddr,
  input  logic                       MemAck,
  input  logic        [WORD_W-1:0]   MemData,
  input  logic                       Stall,
  output logic        [WORD_W-1:0]   Instruction,
  output logic                       InstrValid,
  output logic                       LoadEnable,
  output logic signed [WORD_W-1:0]   LoadValue,
  output logic                       OffsetEnable,
  output logic signed [OFFSET_W-1:0] Offset,
  output logic                       Fault
);

  fetch_state_t        state_q, state_d;
  logic [WORD_W-1:0]   instr_q, instr_d;
  logic [OPCODE_W-1:0] opcode;
  logic                fetching;
  logic                issue_go;
  logic                expire;
  pc_update_t          upd;

  assign opcode   = opcode_of(instr_q);
  assign fetching = (state_q == FS_FETCH) || (state_q == FS_FETCH_TGT);
  assign issue_go = (state_q == FS_ISSUE) && !Stall;

  // ---------------------------------------------------------------------------
  // Optional read timeout
  // ---------------------------------------------------------------------------
`ifdef INSTRUCTION_FETCH_TIMEOUT_EN
  logic fault_q;

  FetchWatchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .Clock  (Clock),
    .Reset  (Reset),
    .Active (fetching),
    .MemAck (MemAck),
    .Expire (expire)
  );

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      fault_q <= 1'b0;
    end else if (expire) begin
      fault_q <= 1'b1;
    end
  end

  assign Fault = fault_q;
`else
  // The parameter only matters to the watchdog; keep it referenced here.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign expire             = 1'b0;
  assign Fault              = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------------
  always_comb begin : next_state
    state_d = state_q;
    instr_d = instr_q;
    case (state_q)
      FS_IDLE: state_d = FS_FETCH;

      FS_FETCH: begin
        if (expire) begin
          state_d = FS_HALTED;
        end else if (MemAck) begin
          instr_d = MemData;
          state_d = FS_ISSUE;
        end
      end

      FS_ISSUE: begin
        if (!Stall) begin
          case (opcode)
            OP_JMP:  state_d = FS_FETCH_TGT;
            OP_HALT: state_d = FS_HALTED;
            default: state_d = FS_FETCH;
          endcase
        end
      end

      // The target word goes straight to ProgramCounter, never into the
      // instruction register.
      FS_FETCH_TGT: begin
        if (expire) begin
          state_d = FS_HALTED;
        end else if (MemAck) begin
          state_d = FS_FETCH;
        end
      end

      FS_HALTED: state_d = FS_HALTED;

      default: state_d = FS_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= FS_IDLE;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Memory read port. The JMP target lives in the word after the JMP, and the
  // PC has not moved since the JMP was fetched, so CounterValue+1 addresses it.
  // ---------------------------------------------------------------------------
  always_comb begin : fetch_port
    MemReq  = 1'b0;
    MemAddr = '0;
    case (state_q)
      FS_FETCH: begin
        MemReq  = 1'b1;
        MemAddr = $unsigned(CounterValue);
      end
      FS_FETCH_TGT: begin
        MemReq  = 1'b1;
        MemAddr = $unsigned(CounterValue) + WORD_W'(1);
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // PC update. Offset steps only happen in ISSUE and loads only in FETCH_TGT,
  // so the two enables are mutually exclusive by construction.
  // ---------------------------------------------------------------------------
  always_comb begin : pc_update
    upd = '0;
    if (issue_go) begin
      case (opcode)
        OP_BRA: begin
          upd.off_en = 1'b1;
          upd.off    = instr_q[OFFSET_W-1:0];
        end
        OP_JMP, OP_HALT: ;
        default: begin
          upd.off_en = 1'b1;
          upd.off    = OFFSET_W'(1);
        end
      endcase
    end
    if ((state_q == FS_FETCH_TGT) && MemAck) begin
      upd.ld_en  = 1'b1;
      upd.ld_val = MemData;
    end
  end

  assign Instruction  = instr_q;
  assign InstrValid   = issue_go;
  assign LoadEnable   = upd.ld_en;
  assign LoadValue    = $signed(upd.ld_val);
  assign OffsetEnable = upd.off_en;
  assign Offset       = $signed(upd.off);

endmodule

// File: tb/tb_instruction_fetch.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch -- directed bench for instruction_fetch. The bench plays
// ProgramCounter and instruction memory, and keeps an architectural model
// (PC, pending JMP target, halted) that is checked every cycle.
// -----------------------------------------------------------------------------
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] CounterValue;
  logic        MemReq;
  logic [15:0] MemAddr;
  logic        MemAck;
  logic [15:0] MemData;
  logic        Stall = 1'b0;
  logic [15:0] Instruction;
  logic        InstrValid;
  logic        LoadEnable;
  logic [15:0] LoadValue;
  logic        OffsetEnable;
  logic [8:0]  Offset;
  logic        Fault;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  instruction_fetch #(.TIMEOUT_CYCLES(16)) dut (
    .Clock        (clk),
    .Reset        (rst_n),
    .CounterValue (CounterValue),
    .MemReq       (MemReq),
    .MemAddr      (MemAddr),
    .MemAck       (MemAck),
    .MemData      (MemData),
    .Stall        (Stall),
    .Instruction  (Instruction),
    .InstrValid   (InstrValid),
    .LoadEnable   (LoadEnable),
    .LoadValue    (LoadValue),
    .OffsetEnable (OffsetEnable),
    .Offset       (Offset),
    .Fault        (Fault)
  );

  // ---------------- environment: memory + program counter -------------------
  logic [15:0] mem [0:65535];
  logic [15:0] start_pc = 16'h0;
  logic [15:0] pc;
  int          mem_wait = 0;
  int          wcnt = 0;
  logic        ack_force = 1'b0;

  assign MemAck       = ack_force || (MemReq && (wcnt >= mem_wait));
  assign MemData      = mem[MemAddr];
  assign CounterValue = pc;

  always @(posedge clk) begin
    if (MemReq && !MemAck) wcnt <= wcnt + 1;
    else                   wcnt <= 0;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)            pc <= start_pc;
    else if (LoadEnable)   pc <= LoadValue;
    else if (OffsetEnable) pc <= pc + {{7{Offset[8]}}, Offset};
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- architectural model, checked every cycle ----------------
  logic [15:0] mpc, jpc, ta, iw;
  bit          tgt, mhalt;

  always @(negedge clk) begin
    if (!rst_n) begin
      mpc = start_pc; tgt = 1'b0; mhalt = 1'b0;
    end else if (mhalt) begin
      chk("m_halt_quiet", {28'd0, MemReq, InstrValid, LoadEnable, OffsetEnable}, 32'd0);
    end else begin
      if (MemReq) begin
        ta = tgt ? jpc + 16'd1 : mpc;
        chk("m_addr", MemAddr, ta);
      end
      if (InstrValid) begin
        iw = mem[mpc];
        chk("m_instr", Instruction, iw);
        case (iw[15:12])
          4'hC: begin
            chk("m_bra_en", OffsetEnable, 1);
            chk("m_bra_off", Offset, iw[8:0]);
            mpc = mpc + {{7{iw[8]}}, iw[8:0]};
          end
          4'hD: begin
            chk("m_jmp_noff", OffsetEnable, 0);
            tgt = 1'b1; jpc = mpc;
          end
          4'hF: begin
            chk("m_halt_noff", OffsetEnable, 0);
            mhalt = 1'b1;
          end
          default: begin
            chk("m_seq_en", OffsetEnable, 1);
            chk("m_seq_off", Offset, 9'd1);
            mpc = mpc + 16'd1;
          end
        endcase
      end else begin
        chk("m_off_idle", OffsetEnable, 0);
      end
      if (LoadEnable) begin
        ta = jpc + 16'd1;
        chk("m_ld_pending", tgt, 1);
        chk("m_ld_val", LoadValue, mem[ta]);
        mpc = mem[ta]; tgt = 1'b0;
      end
      chk("m_excl", LoadEnable & OffsetEnable, 0);
    end
  end

  // ---------------- helpers --------------------------------------------------
  task automatic do_reset(input logic [15:0] spc, input int wt);
    @(posedge clk); #1;
    start_pc = spc; mem_wait = wt; rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_iv(input string nm, input int max, output int cyc);
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!InstrValid && cyc < max);
    n_cmp++;
    if (!InstrValid) begin
      n_bad++;
      $display("FAIL %s: InstrValid got 0 expected 1 within %0d cycles", nm, max);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation got stuck, expected to finish");
    $fatal(1);
  end

  // ---------------- directed stimulus ---------------------------------------
  initial begin
    int cyc;
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    // S0 program
    mem[16'h0400] = 16'h7777;
    // S1: seq, BRA -2, HALT
    mem[16'h0010] = 16'h1234; mem[16'h0011] = 16'hC1FE; mem[16'h000F] = 16'hF000;
    // S2: JMP at FFFF, target word wraps to 0000
    mem[16'hFFFF] = 16'hD000; mem[16'h0000] = 16'h0200; mem[16'h0200] = 16'hF000;
    // S3: throughput
    mem[16'h0100] = 16'h1000; mem[16'h0101] = 16'h2000;
    mem[16'h0102] = 16'h3000; mem[16'h0103] = 16'hF000;
    // S4: stall
    mem[16'h0300] = 16'h5555; mem[16'h0301] = 16'hF000;

    // S0: reset values, ack during reset ignored, reset mid-fetch
    start_pc = 16'h0400; mem_wait = 100; ack_force = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_memreq", MemReq, 0);
    chk("rst_memaddr", MemAddr, 0);
    chk("rst_instr", Instruction, 0);
    chk("rst_ivalid", InstrValid, 0);
    chk("rst_ld", {LoadEnable, LoadValue}, 0);
    chk("rst_off", {OffsetEnable, Offset}, 0);
    chk("rst_fault", Fault, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("idle_memreq", MemReq, 0);
    @(posedge clk); #1 ack_force = 1'b0;
    @(negedge clk);
    chk("fetch_after_idle", {MemReq, MemAddr}, {1'b1, 16'h0400});
    chk("ack_in_idle_ignored", Instruction, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 chk("rst_drops_memreq", {MemReq, MemAddr}, 0);

    // S1: 2 wait states, sequential then BRA -2 then HALT
    do_reset(16'h0010, 2);
    @(negedge clk);
    chk("s1_idle", MemReq, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("s1_addr_hold", {MemReq, InstrValid, MemAddr}, {2'b10, 16'h0010});
    end
    @(negedge clk);
    chk("s1_seq_pulse", {InstrValid, OffsetEnable, LoadEnable}, 3'b110);
    chk("s1_seq_off", Offset, 9'd1);
    chk("s1_seq_instr", Instruction, 16'h1234);
    wait_iv("s1_bra_wait", 20, cyc);
    chk("s1_bra_instr", Instruction, 16'hC1FE);
    chk("s1_bra_off", {OffsetEnable, LoadEnable, Offset}, {2'b10, 9'h1FE});
    wait_iv("s1_halt_wait", 20, cyc);
    chk("s1_halt_instr", Instruction, 16'hF000);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("s1_halted", {MemReq, InstrValid}, 0);
    end

    // S2: JMP with PC wrap
    do_reset(16'hFFFF, 0);
    wait_iv("s2_jmp_wait", 20, cyc);
    chk("s2_jmp", {Instruction, OffsetEnable, LoadEnable}, {16'hD000, 2'b00});
    @(negedge clk);
    chk("s2_tgt_addr", {MemReq, MemAddr}, {1'b1, 16'h0000});
    chk("s2_load", {LoadEnable, OffsetEnable, LoadValue}, {2'b10, 16'h0200});
    @(negedge clk);
    chk("s2_after_load", {MemReq, LoadEnable, MemAddr}, {2'b10, 16'h0200});
    wait_iv("s2_halt_wait", 20, cyc);
    chk("s2_halt", Instruction, 16'hF000);

    // S3: zero-wait sequential throughput, one issue every 2 cycles
    do_reset(16'h0100, 0);
    wait_iv("s3_first", 20, cyc);
    for (int i = 0; i < 3; i++) begin
      wait_iv("s3_next", 20, cyc);
      chk("s3_period", cyc, 2);
    end
    chk("s3_last", Instruction, 16'hF000);

    // S4: stall in ISSUE
    Stall = 1'b1;
    do_reset(16'h0300, 0);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("s4_stalled", {InstrValid, OffsetEnable, MemReq, Instruction}, {3'b000, 16'h5555});
    end
    @(posedge clk); #1 Stall = 1'b0;
    @(negedge clk);
    chk("s4_release", {InstrValid, OffsetEnable, Offset}, {2'b11, 9'd1});
    wait_iv("s4_halt_wait", 20, cyc);
    chk("s4_halt", Instruction, 16'hF000);

    // S5: memory never answers
    do_reset(16'h0500, 1000);
    @(negedge clk);
`ifdef INSTRUCTION_FETCH_TIMEOUT_EN
    repeat (16) @(negedge clk);
    chk("s5_before_timeout", {Fault, MemReq}, 2'b01);
    @(negedge clk);
    chk("s5_timeout", {Fault, MemReq}, 2'b10);
    repeat (5) @(negedge clk);
    chk("s5_halted", {Fault, MemReq, InstrValid}, 3'b100);
`else
    repeat (40) @(negedge clk);
    chk("s5_wait_forever", {Fault, MemReq, MemAddr}, {2'b01, 16'h0500});
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
